multicycle_sequencer: RTL and testbench

- Multicycle FSM that sequences the processor datapath through fetch, decode, execute, memory and writeback.
- Takes the 4-bit opcode from the instruction register and the ALU branch condition.
- Issues per-cycle enables: IR write, PC increment/load, memory request, register write.
- Sits beside control_component. That decoder supplies the static mux selects; this block supplies the timing strobes and owns the memory handshake.

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/multicycle_sequencer_if.sv | 10 +
 rtl/seq_wait_timer.sv | 42 ++++
 rtl/multicycle_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle sequencer: state encoding, opcode
// constants matching control_component, and opcode classification helpers.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_FAULT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_GRT  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_EQ   = 4'b0011;
  localparam logic [3:0] OP_JALR = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_JAL  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_LW   = 4'b1001;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_LLI  = 4'b1111;

  // Loads and stores are the only instructions that visit MEM.
  function automatic logic op_is_mem(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Register-writing ALU operations that retire through WB.
  function automatic logic op_is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_GRT) ||
           (op == OP_EQ)  || (op == OP_ADDI) || (op == OP_LUI) ||
           (op == OP_LLI);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Memory handshake bundle between the sequencer (master) and memory (slave).
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ack);
endinterface

// File: rtl/seq_wait_timer.sv
// Memory wait counter. Counts non-acknowledged access cycles, saturates, and
// flags the cycle whose increment would reach WAIT_MAX. WAIT_MAX=0 disables it.
module seq_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT  = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX) : {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on access entry, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is combinational on the current count so the FSM can leave the
  // access state in the same cycle the limit is hit.
  assign expired_o = (WAIT_MAX > 0) && en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle fetch/decode/execute/mem/writeback sequencer. Produces timing
// strobes and owns the memory handshake; static mux selects come from the
// decoder. Optional SEQ_PERF_CNT_EN adds retired/stall performance counters.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic                          clk,
  input  logic                          reset_n,
  multicycle_sequencer_if.master        mem_if,
  input  logic [3:0]                    op,
  input  logic                          branch_cond,
  input  logic                          stall,
  output logic                          ir_write,
  output logic                          pc_inc,
  output logic                          pc_load,
  output logic                          alu_en,
  output logic                          reg_write,
  output logic                          instr_done,
  output logic                          fault,
  output logic [2:0]                    state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                   retired_cnt,
  output logic [31:0]                   stall_cnt
`endif
);

  state_t state_q, state_d;
  logic   in_access;
  logic   ack_ok;
  logic   wait_en;
  logic   wait_clr;
  logic   wait_expired;
  logic   mem_req, mem_we, mem_sel;

  // Ack only counts in an access state and never while stalled.
  assign in_access = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign ack_ok    = in_access && !stall && mem_if.mem_ack;
  assign wait_en   = in_access && !stall && !mem_if.mem_ack;
  assign wait_clr  = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);

  seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (wait_clr),
    .en_i     (wait_en),
    .expired_o(wait_expired)
  );

  // Next-state selection; stall freezes every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (ack_ok)            state_d = ST_DECODE;
        else if (wait_expired) state_d = ST_FAULT;
      end
      ST_DECODE: if (!stall) state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (!stall) begin
          if (op_is_mem(op))                      state_d = ST_MEM;
          else if (op_is_alu(op) || op == OP_JAL) state_d = ST_WB;
          else                                    state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (ack_ok)            state_d = (op == OP_SW) ? ST_FETCH : ST_WB;
        else if (wait_expired) state_d = ST_FAULT;
      end
      ST_WB:     if (!stall) state_d = ST_FETCH;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode of the state register, with ack-qualified fetch/store strobes.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_en     = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    fault      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (ack_ok) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
        end
      end
      ST_EXECUTE: begin
        if (!stall) begin
          alu_en = 1'b1;
          if (op == OP_JAL) begin
            pc_load = 1'b1;
          end else if (op == OP_JALR) begin
            pc_load    = 1'b1;
            instr_done = 1'b1;
          end else if (!op_is_mem(op) && !op_is_alu(op)) begin
            pc_load    = branch_cond;
            instr_done = 1'b1;
          end
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (op == OP_SW);
        if (ack_ok && (op == OP_SW)) instr_done = 1'b1;
      end
      ST_WB: begin
        if (!stall) begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign mem_if.mem_req = mem_req;
  assign mem_if.mem_we  = mem_we;
  assign mem_if.mem_sel = mem_sel;
  assign state          = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Performance counter next values; both wrap naturally at 2^32.
  always_comb begin
    retired_cnt_d = retired_cnt_q + {31'd0, instr_done};
    stall_cnt_d   = stall_cnt_q;
    if (stall && (state_q != ST_IDLE) && (state_q != ST_FAULT)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: the stimulus process queues the
// hand-derived expected state/strobe vector for each driven cycle and a
// monitor process pops and compares it mid-cycle.
module tb_multicycle_sequencer;
  import seq_pkg::*;

  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3,
                         S_M = 3'd4, S_W = 3'd5, S_X = 3'd7;
  // {req,we,sel,ir_write,pc_inc,pc_load,alu_en,reg_write,instr_done,fault}
  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_FACK = 10'b1001100000;
  localparam logic [9:0] O_FW   = 10'b1000000000;
  localparam logic [9:0] O_EXE  = 10'b0000001000;
  localparam logic [9:0] O_EPL  = 10'b0000011000;
  localparam logic [9:0] O_EBR  = 10'b0000011010;
  localparam logic [9:0] O_EBN  = 10'b0000001010;
  localparam logic [9:0] O_MLW  = 10'b1010000000;
  localparam logic [9:0] O_MSWA = 10'b1110000010;
  localparam logic [9:0] O_WB   = 10'b0000000110;
  localparam logic [9:0] O_FLT  = 10'b0000000001;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [9:0] o;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] op;
  logic       branch_cond;
  logic       stall;
  logic       ir_write, pc_inc, pc_load, alu_en, reg_write, instr_done, fault;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  multicycle_sequencer_if mif();

  multicycle_sequencer #(.WAIT_MAX(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_if     (mif),
    .op         (op),
    .branch_cond(branch_cond),
    .stall      (stall),
    .ir_write   (ir_write),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .alu_en     (alu_en),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .fault      (fault),
    .state      (state)
`ifdef SEQ_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: compare the queued expectation for this cycle at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e   = sb.pop_front();
      act = {mif.mem_req, mif.mem_we, mif.mem_sel, ir_write, pc_inc, pc_load,
             alu_en, reg_write, instr_done, fault};
      n_chk++;
      if ((state !== e.st) || (act !== e.o)) begin
        n_fail++;
        $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                 e.tag, state, act, e.st, e.o);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic cyc(input string tag, input logic rn, input logic stl,
                     input logic ack, input logic bc,
                     input logic [2:0] st, input logic [9:0] o);
    exp_t e;
    reset_n     = rn;
    stall       = stl;
    mif.mem_ack = ack;
    branch_cond = bc;
    e.tag = tag;
    e.st  = st;
    e.o   = o;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; mif.mem_ack = 1'b0; branch_cond = 1'b0; op = OP_ADD;
    @(posedge clk); #1;
    cyc("reset0", 0, 0, 1, 0, S_I, O_NONE);
    cyc("reset1", 0, 0, 1, 0, S_I, O_NONE);
    cyc("idle_release", 1, 0, 1, 0, S_I, O_NONE);

    // Two back-to-back adds with zero-wait memory.
    for (int i = 0; i < 2; i++) begin
      cyc("add_fetch", 1, 0, 1, 0, S_F, O_FACK);
      cyc("add_decode", 1, 0, 1, 0, S_D, O_NONE);
      cyc("add_exec", 1, 0, 1, 0, S_E, O_EXE);
      cyc("add_wb", 1, 0, 1, 0, S_W, O_WB);
    end

    // lw with three wait cycles in MEM.
    op = OP_LW;
    cyc("lw_fetch", 1, 0, 1, 0, S_F, O_FACK);
    cyc("lw_decode", 1, 0, 0, 0, S_D, O_NONE);
    cyc("lw_exec", 1, 0, 0, 0, S_E, O_EXE);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1, 0, 0, 0, S_M, O_MLW);
    cyc("lw_mem_ack", 1, 0, 1, 0, S_M, O_MLW);
    cyc("lw_wb", 1, 0, 0, 0, S_W, O_WB);

    // sw zero-wait retires from MEM.
    op = OP_SW;
    cyc("sw_fetch", 1, 0, 1, 0, S_F, O_FACK);
    cyc("sw_decode", 1, 0, 1, 0, S_D, O_NONE);
    cyc("sw_exec", 1, 0, 1, 0, S_E, O_EXE);
    cyc("sw_mem_ack", 1, 0, 1, 0, S_M, O_MSWA);

    // bne taken then not taken.
    op = OP_BNE;
    cyc("bne_t_fetch", 1, 0, 1, 1, S_F, O_FACK);
    cyc("bne_t_decode", 1, 0, 1, 1, S_D, O_NONE);
    cyc("bne_t_exec", 1, 0, 1, 1, S_E, O_EBR);
    cyc("bne_n_fetch", 1, 0, 1, 0, S_F, O_FACK);
    cyc("bne_n_decode", 1, 0, 1, 0, S_D, O_NONE);
    cyc("bne_n_exec", 1, 0, 1, 0, S_E, O_EBN);

    // jal links through WB; jalr retires from EXECUTE.
    op = OP_JAL;
    cyc("jal_fetch", 1, 0, 1, 0, S_F, O_FACK);
    cyc("jal_decode", 1, 0, 1, 0, S_D, O_NONE);
    cyc("jal_exec", 1, 0, 1, 0, S_E, O_EPL);
    cyc("jal_wb", 1, 0, 1, 0, S_W, O_WB);
    op = OP_JALR;
    cyc("jalr_fetch", 1, 0, 1, 0, S_F, O_FACK);
    cyc("jalr_decode", 1, 0, 1, 0, S_D, O_NONE);
    cyc("jalr_exec", 1, 0, 1, 0, S_E, O_EBR);

    // Stall beats ack in FETCH and gates strobes in later states.
    op = OP_ADD;
    for (int i = 0; i < 5; i++) cyc("stall_fetch", 1, 1, 1, 0, S_F, O_FW);
    cyc("stall_fetch_rel", 1, 0, 1, 0, S_F, O_FACK);
    cyc("stall_decode", 1, 1, 1, 0, S_D, O_NONE);
    cyc("decode_rel", 1, 0, 1, 0, S_D, O_NONE);
    cyc("stall_exec", 1, 1, 1, 0, S_E, O_NONE);
    cyc("exec_rel", 1, 0, 1, 0, S_E, O_EXE);
    cyc("stall_wb", 1, 1, 1, 0, S_W, O_NONE);
    cyc("wb_rel", 1, 0, 1, 0, S_W, O_WB);

    // 14 waits in FETCH and again in MEM stay just under the limit.
    op = OP_LW;
    for (int i = 0; i < 14; i++) cyc("edge_fetch_wait", 1, 0, 0, 0, S_F, O_FW);
    cyc("edge_fetch_ack", 1, 0, 1, 0, S_F, O_FACK);
    cyc("edge_decode", 1, 0, 0, 0, S_D, O_NONE);
    cyc("edge_exec", 1, 0, 0, 0, S_E, O_EXE);
    for (int i = 0; i < 14; i++) cyc("edge_mem_wait", 1, 0, 0, 0, S_M, O_MLW);
    cyc("edge_mem_ack", 1, 0, 1, 0, S_M, O_MLW);
    cyc("edge_wb", 1, 0, 0, 0, S_W, O_WB);

    // 15 unacknowledged FETCH cycles fault; fault is sticky until reset.
    op = OP_ADD;
    for (int i = 0; i < 15; i++) cyc("to_fetch_wait", 1, 0, 0, 0, S_F, O_FW);
    for (int i = 0; i < 3; i++) cyc("fault_sticky", 1, 0, 1, 0, S_X, O_FLT);
    cyc("fault_reset", 0, 0, 0, 0, S_I, O_NONE);
    cyc("fault_release", 1, 0, 0, 0, S_I, O_NONE);

    // Reset asserted in the middle of a MEM wait.
    op = OP_LW;
    cyc("mr_fetch", 1, 0, 1, 0, S_F, O_FACK);
    cyc("mr_decode", 1, 0, 0, 0, S_D, O_NONE);
    cyc("mr_exec", 1, 0, 0, 0, S_E, O_EXE);
    cyc("mr_mem_wait", 1, 0, 0, 0, S_M, O_MLW);
    cyc("mr_reset", 0, 0, 0, 0, S_I, O_NONE);
    cyc("mr_release", 1, 0, 1, 0, S_I, O_NONE);
    op = OP_ADD;
    cyc("mr_fetch2", 1, 0, 1, 0, S_F, O_FACK);
    cyc("mr_decode2", 1, 0, 1, 0, S_D, O_NONE);

`ifdef SEQ_PERF_CNT_EN
    // Counters: 10 adds with 2 stalled DECODE cycles, then reset mid-MEM.
    cyc("pc_reset", 0, 0, 1, 0, S_I, O_NONE);
    cyc("pc_release", 1, 0, 1, 0, S_I, O_NONE);
    for (int i = 0; i < 10; i++) begin
      cyc("pc_fetch", 1, 0, 1, 0, S_F, O_FACK);
      if (i == 3 || i == 7) cyc("pc_stall", 1, 1, 1, 0, S_D, O_NONE);
      cyc("pc_decode", 1, 0, 1, 0, S_D, O_NONE);
      cyc("pc_exec", 1, 0, 1, 0, S_E, O_EXE);
      cyc("pc_wb", 1, 0, 1, 0, S_W, O_WB);
    end
    chk32("retired_cnt", retired_cnt, 32'd10);
    chk32("stall_cnt", stall_cnt, 32'd2);
    op = OP_LW;
    cyc("pc_lw_fetch", 1, 0, 1, 0, S_F, O_FACK);
    cyc("pc_lw_decode", 1, 0, 0, 0, S_D, O_NONE);
    cyc("pc_lw_exec", 1, 0, 0, 0, S_E, O_EXE);
    cyc("pc_lw_mem", 1, 0, 0, 0, S_M, O_MLW);
    reset_n = 1'b0;
    #1;
    chk32("retired_cnt_reset", retired_cnt, 32'd0);
    chk32("stall_cnt_reset", stall_cnt, 32'd0);
    cyc("pc_mem_reset", 0, 0, 0, 0, S_I, O_NONE);
`endif

    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
